// File: rtl/vji_host_pkg.sv
// Shared constants for the virtual-JTAG host driver.
// Holds FSM state codes, Nios II debug IR codes and default widths.
package vji_host_pkg;

    localparam int unsigned DR_WIDTH_DEFAULT = 38;
    localparam int unsigned IR_WIDTH_DEFAULT = 2;
    localparam int unsigned TCK_CNT_W        = 4;
    localparam int unsigned BIT_CNT_W        = 6;

    // Debug-slave virtual IR codes
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    // Host FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_UIR   = 3'd1;
    localparam state_t ST_CDR   = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_UDR   = 3'd4;
    localparam state_t ST_RTI   = 3'd5;
    localparam state_t ST_RESP  = 3'd6;

endpackage

// File: rtl/vji_tck_gen.sv
// Test-clock generator: while run is high, tck toggles every TCK_DIV clk
// cycles starting with a low phase; tck is held low whenever run is low.
// Ports: clk, reset (sync, active-high), run in; tck (registered),
//        rise_c / fall_c (combinational: tck changes 0->1 / 1->0 at the next edge).
module vji_tck_gen
    import vji_host_pkg::*;
#(
    parameter int unsigned TCK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic rise_c,
    output logic fall_c
);

    logic [TCK_CNT_W-1:0] cnt;
    logic                 wrap_c;

    assign wrap_c = run && (cnt == TCK_CNT_W'(TCK_DIV - 1));
    assign rise_c = wrap_c && !tck;
    assign fall_c = wrap_c && tck;

    // Phase counter; idle forces the low phase so every run starts low
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (wrap_c) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vji_host_driver.sv
// Host-side virtual-JTAG initiator for the Nios II debug slave.
// Accepts an IR(+DR) command, walks UIR -> [CDR -> SHIFT -> UDR] -> RTI one
// tck period per state (SHIFT lasts DR_WIDTH periods), then returns the
// captured tdo bits and ir_out on the response interface.
// Ports: clk, reset; cmd_* (valid/ready command); rsp_* (valid/ready
//        response); vji_* (virtual TAP pins toward the slave); busy.
module vji_host_driver
    import vji_host_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int unsigned IR_WIDTH = IR_WIDTH_DEFAULT,
    parameter int unsigned TCK_DIV  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic                cmd_ir_only,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic                busy
);

    state_t                 state;
    state_t                 state_d;
    logic                   run_c;
    logic                   rise_c;
    logic                   fall_c;
    logic [DR_WIDTH-1:0]    sr;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   ir_only_q;
    logic [IR_WIDTH-1:0]    ir_cap;

    // tck runs in every scan state; held low in IDLE and RESP
    assign run_c = (state != ST_IDLE) && (state != ST_RESP);

    vji_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk    (clk),
        .reset  (reset),
        .run    (run_c),
        .tck    (vji_tck),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state: every scan state ends on a tck falling edge
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_d = ST_UIR;
            ST_UIR:   if (fall_c) state_d = ir_only_q ? ST_RTI : ST_CDR;
            ST_CDR:   if (fall_c) state_d = ST_SHIFT;
            ST_SHIFT: if (fall_c && (bit_cnt == BIT_CNT_W'(DR_WIDTH))) state_d = ST_UDR;
            ST_UDR:   if (fall_c) state_d = ST_RTI;
            ST_RTI:   if (fall_c) state_d = ST_RESP;
            ST_RESP:  if (rsp_valid && rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, shifter and response path
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            sr         <= '0;
            bit_cnt    <= '0;
            ir_only_q  <= 1'b0;
            ir_cap     <= '0;
            rsp_valid  <= 1'b0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
        end else begin
            // Flags follow the next state so they change together with it
            cmd_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            vji_uir   <= (state_d == ST_UIR);
            vji_cdr   <= (state_d == ST_CDR);
            vji_sdr   <= (state_d == ST_SHIFT);
            vji_udr   <= (state_d == ST_UDR);
            vji_rti   <= (state_d == ST_RTI);

            if (state == ST_IDLE && cmd_valid) begin
                vji_ir_in <= cmd_ir;
                sr        <= cmd_dr;
                ir_only_q <= cmd_ir_only;
            end

            if (state == ST_UIR && rise_c) begin
                ir_cap <= vji_ir_out;
            end

            if (state == ST_CDR && fall_c) begin
                bit_cnt <= '0;
            end

            // Slave drives tdo before the rise; capture it into the MSB
            if (state == ST_SHIFT && rise_c) begin
                sr      <= {vji_tdo, sr[DR_WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end

            // tdi only moves on falls so it is stable across each rise
            if (fall_c) begin
                vji_tdi <= (state_d == ST_SHIFT) ? sr[0] : 1'b0;
            end

            if (rsp_valid) begin
                if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                end
            end else if (state == ST_RESP) begin
                rsp_valid  <= 1'b1;
                rsp_dr     <= ir_only_q ? '0 : sr;
                rsp_ir_out <= ir_cap;
            end
        end
    end

endmodule
